// File: rtl/operand_fwd_ctrl.sv
// Forwarding and load-use hazard control for the EX-stage operand muxes.
// Tracks the destinations of the EX and MEM instructions and registers mux selects into EX.
module operand_fwd_ctrl #(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_imm,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_we,
    input  logic              i_id_is_load,
    input  logic              i_flush,
    output logic [1:0]        o_sel_a,
    output logic [1:0]        o_sel_b,
    output logic              o_mux_en,
    output logic              o_stall,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    localparam logic [1:0] SelRf  = 2'b00;
    localparam logic [1:0] SelEx  = 2'b01;
    localparam logic [1:0] SelMem = 2'b10;
    localparam logic [1:0] SelImm = 2'b11;

    logic              r_ex_vld;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_ld;
    logic              r_mem_vld;
    logic [REG_AW-1:0] r_mem_rd;
    logic [1:0]        r_sel_a;
    logic [1:0]        r_sel_b;
    logic              r_mux_en;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic       w_rs1_nz;
    logic       w_rs2_used;
    logic       w_ex_hit_a;
    logic       w_ex_hit_b;
    logic       w_mem_hit_a;
    logic       w_mem_hit_b;
    logic       w_stall;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    // Slots only ever hold rd != 0, so a valid match already excludes r0.
    assign w_rs1_nz    = (i_id_rs1 != '0);
    assign w_rs2_used  = !i_id_use_imm && (i_id_rs2 != '0);
    assign w_ex_hit_a  = w_rs1_nz && r_ex_vld && (r_ex_rd == i_id_rs1);
    assign w_ex_hit_b  = w_rs2_used && r_ex_vld && (r_ex_rd == i_id_rs2);
    assign w_mem_hit_a = w_rs1_nz && r_mem_vld && (r_mem_rd == i_id_rs1);
    assign w_mem_hit_b = w_rs2_used && r_mem_vld && (r_mem_rd == i_id_rs2);

    assign w_stall = i_id_valid && !i_flush && r_ex_ld && (w_ex_hit_a || w_ex_hit_b);

    always_comb begin
        w_sel_a = SelRf;
        w_sel_b = SelRf;
        if (w_ex_hit_a) begin
            w_sel_a = SelEx;
        end else if (w_mem_hit_a) begin
            w_sel_a = SelMem;
        end
        if (i_id_use_imm) begin
            w_sel_b = SelImm;
        end else if (w_ex_hit_b) begin
            w_sel_b = SelEx;
        end else if (w_mem_hit_b) begin
            w_sel_b = SelMem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_vld    <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_ld     <= 1'b0;
            r_mem_vld   <= 1'b0;
            r_mem_rd    <= '0;
            r_sel_a     <= SelRf;
            r_sel_b     <= SelRf;
            r_mux_en    <= 1'b0;
            r_stall_cnt <= '0;
        end else if (i_flush) begin
            r_ex_vld  <= 1'b0;
            r_ex_ld   <= 1'b0;
            r_mem_vld <= 1'b0;
            r_sel_a   <= SelRf;
            r_sel_b   <= SelRf;
            r_mux_en  <= 1'b0;
        end else begin
            r_mem_vld <= r_ex_vld;
            r_mem_rd  <= r_ex_rd;
            if (i_id_valid && !w_stall) begin
                r_ex_vld <= i_id_we && (i_id_rd != '0);
                r_ex_rd  <= i_id_rd;
                r_ex_ld  <= i_id_is_load;
                r_sel_a  <= w_sel_a;
                r_sel_b  <= w_sel_b;
                r_mux_en <= 1'b1;
            end else begin
                r_ex_vld <= 1'b0;
                r_ex_ld  <= 1'b0;
                r_sel_a  <= SelRf;
                r_sel_b  <= SelRf;
                r_mux_en <= 1'b0;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sel_a     = r_sel_a;
    assign o_sel_b     = r_sel_b;
    assign o_mux_en    = r_mux_en;
    assign o_stall     = w_stall;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Randomized bench for operand_fwd_ctrl against a stage-level pipeline model,
// plus directed scenarios with hand-computed expectations.
module tb_operand_fwd_ctrl;

    localparam int unsigned REG_AW = 4;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_rs1 = '0;
    logic [REG_AW-1:0] id_rs2 = '0;
    logic              id_use_imm = 1'b0;
    logic [REG_AW-1:0] id_rd = '0;
    logic              id_we = 1'b0;
    logic              id_is_load = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              mux_en;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int failures = 0;

    operand_fwd_ctrl #(
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_id_valid   (id_valid),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .i_id_use_imm (id_use_imm),
        .i_id_rd      (id_rd),
        .i_id_we      (id_we),
        .i_id_is_load (id_is_load),
        .i_flush      (flush),
        .o_sel_a      (sel_a),
        .o_sel_b      (sel_b),
        .o_mux_en     (mux_en),
        .o_stall      (stall),
        .o_stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Model: which instruction sits in EX and MEM, and what EX sees this cycle.
    typedef struct packed {
        logic              writes;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } instr_t;

    instr_t m_ex = '0;
    instr_t m_mem = '0;
    int m_sel_a = 0;
    int m_sel_b = 0;
    int m_en = 0;
    int m_cnt = 0;
    int max_cnt = (1 << CNT_W) - 1;

    function automatic int fwd(input logic [REG_AW-1:0] rs);
        if (rs == 0) return 0;
        if (m_ex.writes && m_ex.rd == rs) return 1;
        if (m_mem.writes && m_mem.rd == rs) return 2;
        return 0;
    endfunction

    function automatic bit m_stall();
        bit uses;
        uses = (m_ex.rd == id_rs1) || (!id_use_imm && m_ex.rd == id_rs2);
        return id_valid && !flush && m_ex.writes && m_ex.ld && uses;
    endfunction

    task automatic m_reset();
        m_ex = '0; m_mem = '0; m_sel_a = 0; m_sel_b = 0; m_en = 0; m_cnt = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        chk("stall", int'(stall), int'(m_stall()));
        chk("sel_a", int'(sel_a), m_sel_a);
        chk("sel_b", int'(sel_b), m_sel_b);
        chk("mux_en", int'(mux_en), m_en);
        chk("stall_cnt", int'(stall_cnt), m_cnt);
    end

    task automatic tick();
        instr_t n_ex, n_mem;
        int n_a, n_b, n_en, n_cnt;
        n_ex = '0; n_mem = m_ex; n_a = 0; n_b = 0; n_en = 0; n_cnt = m_cnt;
        if (flush) begin
            n_mem = '0;
        end else if (m_stall()) begin
            if (n_cnt < max_cnt) n_cnt++;
        end else if (id_valid) begin
            n_ex.writes = id_we && (id_rd != 0);
            n_ex.rd = id_rd;
            n_ex.ld = id_is_load;
            n_a = fwd(id_rs1);
            n_b = id_use_imm ? 3 : fwd(id_rs2);
            n_en = 1;
        end
        @(posedge clk);
        m_ex = n_ex; m_mem = n_mem; m_sel_a = n_a; m_sel_b = n_b; m_en = n_en; m_cnt = n_cnt;
        #1;
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input bit imm,
                         input int rd, input bit we, input bit ld);
        id_valid = v; id_rs1 = REG_AW'(rs1); id_rs2 = REG_AW'(rs2); id_use_imm = imm;
        id_rd = REG_AW'(rd); id_we = we; id_is_load = ld; flush = 1'b0;
    endtask

    task automatic nops();
        drive(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    endtask

    initial begin
        #12;
        chk("reset_sel_a", int'(sel_a), 0);
        chk("reset_mux_en", int'(mux_en), 0);
        chk("reset_cnt", int'(stall_cnt), 0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back ALU
        nops();
        drive(1, 1, 1, 1, 3, 1, 0); tick();
        drive(1, 3, 0, 1, 8, 1, 0); #1 chk("b2b_stall", int'(stall), 0); tick();
        chk("b2b_sel_a", int'(sel_a), 1);
        chk("b2b_en", int'(mux_en), 1);

        // Distance two
        nops();
        drive(1, 0, 0, 1, 5, 1, 0); tick();
        drive(1, 0, 0, 1, 7, 1, 0); tick();
        drive(1, 0, 5, 0, 9, 1, 0); tick();
        chk("dist2_sel_b", int'(sel_b), 2);
        chk("dist2_sel_a", int'(sel_a), 0);

        // Double match: younger wins
        nops();
        drive(1, 0, 0, 1, 2, 1, 0); tick();
        drive(1, 0, 0, 1, 2, 1, 0); tick();
        drive(1, 2, 2, 0, 9, 1, 0); tick();
        chk("dbl_sel_a", int'(sel_a), 1);
        chk("dbl_sel_b", int'(sel_b), 1);

        // r0 and immediate
        nops();
        drive(1, 0, 0, 1, 0, 1, 0); tick();
        drive(1, 0, 0, 1, 9, 1, 0); tick();
        chk("r0_sel_a", int'(sel_a), 0);
        nops();
        drive(1, 0, 0, 1, 6, 1, 0); tick();
        drive(1, 0, 6, 1, 9, 1, 0); tick();
        chk("imm_sel_b", int'(sel_b), 3);

        // Load-use
        nops();
        drive(1, 0, 0, 1, 4, 1, 1); tick();
        drive(1, 4, 0, 1, 9, 1, 0); #1 chk("lu_stall", int'(stall), 1); tick();
        chk("lu_bubble_en", int'(mux_en), 0);
        chk("lu_stall_drop", int'(stall), 0);
        tick();
        chk("lu_sel_a", int'(sel_a), 2);
        chk("lu_cnt", int'(stall_cnt), 1);

        // Saturation
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 1, 4, 1, 1); tick();
            drive(1, 0, 4, 0, 9, 1, 0); tick(); tick();
        end
        chk("sat_cnt", int'(stall_cnt), 15);

        // Flush during load-use
        nops();
        drive(1, 0, 0, 1, 4, 1, 1); tick();
        drive(1, 4, 0, 1, 9, 1, 0); #1 chk("fl_pre_stall", int'(stall), 1);
        flush = 1'b1; #1 chk("fl_stall", int'(stall), 0);
        tick();
        chk("fl_en", int'(mux_en), 0);
        drive(1, 4, 0, 1, 9, 1, 0); tick();
        chk("fl_sel_a", int'(sel_a), 0);
        chk("fl_cnt", int'(stall_cnt), 15);

        // Mid-stream reset
        drive(1, 0, 0, 1, 3, 1, 0); tick();
        drive(1, 3, 3, 0, 5, 1, 0); tick();
        rst_n = 1'b0; #1;
        m_reset();
        chk("rst_sel_a", int'(sel_a), 0);
        chk("rst_sel_b", int'(sel_b), 0);
        chk("rst_en", int'(mux_en), 0);
        chk("rst_cnt", int'(stall_cnt), 0);
        @(negedge clk); #1 rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Random traffic; a stalled instruction is held by upstream.
        for (int i = 0; i < 3000; i++) begin
            if (!(stall && !flush)) begin
                drive(($urandom_range(0, 7) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                      ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            end
            flush = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
